// File: rtl/writeback_stage.sv
// Final pipeline stage. It registers retiring instructions, waits for load data, extends
// and selects the writeback value, drives the register-file write port and counts retirements.
`timescale 1ns/1ps

module writeback_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_pc_next,
    input  logic [31:0]      in_immediate,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_we,
    input  logic [1:0]       in_mem_op,
    input  logic [2:0]       in_mem_sel,
    input  logic [1:0]       in_wb_sel,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_we,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;
    localparam logic [1:0] WB_SEL_MEM   = 2'b01;
    localparam logic [1:0] WB_SEL_PC    = 2'b10;
    localparam logic [1:0] WB_SEL_IMM   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic             pend_we_q, pend_we_d;
    logic             pend_mem_q, pend_mem_d;
    logic [1:0]       pend_off_q, pend_off_d;
    logic [2:0]       pend_sel_q, pend_sel_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             in_is_load;
    logic             in_is_store;
    logic [31:0]      direct_value;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  sel);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (sel)
            3'b000:  extend_load = {{24{lane_b[7]}}, lane_b};
            3'b001:  extend_load = {{16{lane_h[15]}}, lane_h};
            3'b100:  extend_load = {24'd0, lane_b};
            3'b101:  extend_load = {16'd0, lane_h};
            default: extend_load = word;
        endcase
    endfunction

    assign in_ready    = (state_q != WAIT_LOAD);
    assign accept      = in_valid & in_ready;
    assign in_is_load  = (in_mem_op == MEM_OP_LOAD);
    assign in_is_store = (in_mem_op == MEM_OP_STORE);

    // Everything except load data is known at accept; wb_sel=MEM without a load falls back to ALU.
    always_comb begin
        case (in_wb_sel)
            WB_SEL_PC:  direct_value = in_pc_next;
            WB_SEL_IMM: direct_value = in_immediate;
            default:    direct_value = in_alu_result;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_we_d   = pend_we_q;
        pend_mem_d  = pend_mem_q;
        pend_off_d  = pend_off_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_we_d     = 1'b0;
        count_d     = count_q;

        case (state_q)
            IDLE, COMMIT: begin
                if (accept && in_is_load) begin
                    state_d     = WAIT_LOAD;
                    pend_rd_d   = in_rd;
                    pend_we_d   = in_reg_we;
                    pend_mem_d  = (in_wb_sel == WB_SEL_MEM);
                    pend_off_d  = in_alu_result[1:0];
                    pend_sel_d  = in_mem_sel;
                    pend_data_d = direct_value;
                end else if (accept) begin
                    state_d   = COMMIT;
                    wb_rd_d   = in_rd;
                    wb_data_d = direct_value;
                    wb_we_d   = in_reg_we & (in_rd != 5'd0) & ~in_is_store;
                    count_d   = count_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d   = COMMIT;
                    wb_rd_d   = pend_rd_q;
                    wb_data_d = pend_mem_q ? extend_load(mem_rdata, pend_off_q, pend_sel_q)
                                           : pend_data_q;
                    wb_we_d   = pend_we_q & (pend_rd_q != 5'd0);
                    count_d   = count_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_rd_q   <= 5'd0;
            pend_we_q   <= 1'b0;
            pend_mem_q  <= 1'b0;
            pend_off_q  <= 2'd0;
            pend_sel_q  <= 3'd0;
            pend_data_q <= 32'd0;
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= 32'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_we_q   <= pend_we_d;
            pend_mem_q  <= pend_mem_d;
            pend_off_q  <= pend_off_d;
            pend_sel_q  <= pend_sel_d;
            pend_data_q <= pend_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_data_q   <= wb_data_d;
            count_q     <= count_d;
        end
    end

    assign wb_rd        = wb_rd_q;
    assign wb_reg_we    = wb_we_q;
    assign wb_data      = wb_data_q;
    assign retire_count = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed vector bench for writeback_stage: a table of single instructions plus
// hand-written sequences for back-to-back commits, reset during a load and counter wrap.
`timescale 1ns/1ps

module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [31:0] in_alu_result, in_pc_next, in_immediate;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic [1:0]  in_mem_op;
    logic [2:0]  in_mem_sel;
    logic [1:0]  in_wb_sel;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  wb_rd, wb_rd4;
    logic        wb_reg_we, wb_reg_we4;
    logic [31:0] wb_data, wb_data4;
    logic [31:0] retire_count;
    logic [3:0]  retire_count4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc_next;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_we;
        logic [1:0]  mem_op;
        logic [2:0]  mem_sel;
        logic [1:0]  wb_sel;
        logic [31:0] rdata;
        int          waits;
        logic        exp_we;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    writeback_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_pc_next(in_pc_next), .in_immediate(in_immediate),
        .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_op(in_mem_op), .in_mem_sel(in_mem_sel),
        .in_wb_sel(in_wb_sel), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data), .retire_count(retire_count)
    );

    // Narrow-counter copy sharing the same stimulus, used to observe the wrap.
    writeback_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_alu_result(in_alu_result), .in_pc_next(in_pc_next), .in_immediate(in_immediate),
        .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_op(in_mem_op), .in_mem_sel(in_mem_sel),
        .in_wb_sel(in_wb_sel), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_rd(wb_rd4), .wb_reg_we(wb_reg_we4), .wb_data(wb_data4), .retire_count(retire_count4)
    );

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] pc_next,
                                input logic [31:0] imm, input logic [31:0] rd,
                                input logic [31:0] reg_we, input logic [31:0] mem_op,
                                input logic [31:0] mem_sel, input logic [31:0] wb_sel,
                                input logic [31:0] rdata, input int waits,
                                input logic [31:0] exp_we, input logic [31:0] chk_data,
                                input logic [31:0] exp_data);
        vec_t v;
        v.alu      = alu;
        v.pc_next  = pc_next;
        v.imm      = imm;
        v.rd       = rd[4:0];
        v.reg_we   = reg_we[0];
        v.mem_op   = mem_op[1:0];
        v.mem_sel  = mem_sel[2:0];
        v.wb_sel   = wb_sel[1:0];
        v.rdata    = rdata;
        v.waits    = waits;
        v.exp_we   = exp_we[0];
        v.chk_data = chk_data[0];
        v.exp_data = exp_data;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name);
        checkOutput({name, "_count"}, retire_count, exp_count);
        checkOutput({name, "_count4"}, {28'd0, retire_count4}, {28'd0, exp_count[3:0]});
    endtask

    task automatic idleInputs();
        in_valid      = 1'b0;
        in_alu_result = 32'd0;
        in_pc_next    = 32'd0;
        in_immediate  = 32'd0;
        in_rd         = 5'd0;
        in_reg_we     = 1'b0;
        in_mem_op     = 2'b00;
        in_mem_sel    = 3'b000;
        in_wb_sel     = 2'b00;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'd0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string n;
        n = $sformatf("v%0d", idx);
        in_alu_result = v.alu;
        in_pc_next    = v.pc_next;
        in_immediate  = v.imm;
        in_rd         = v.rd;
        in_reg_we     = v.reg_we;
        in_mem_op     = v.mem_op;
        in_mem_sel    = v.mem_sel;
        in_wb_sel     = v.wb_sel;
        in_valid      = 1'b1;
        tick();
        in_valid = 1'b0;
        if (v.mem_op == 2'b01) begin
            checkOutput({n, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
            for (int i = 0; i < v.waits; i++) begin
                checkOutput({n, "_we_wait"}, {31'd0, wb_reg_we}, 32'd0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end
        exp_count++;
        checkOutput({n, "_we"}, {31'd0, wb_reg_we}, {31'd0, v.exp_we});
        if (v.chk_data) begin
            checkOutput({n, "_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
            checkOutput({n, "_data"}, wb_data, v.exp_data);
        end
        checkCount(n);
        tick();
        checkOutput({n, "_we_after"}, {31'd0, wb_reg_we}, 32'd0);
        checkOutput({n, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 32'd0;
    endtask

    initial begin
        // alu, pc_next, imm, rd, we, mem_op, mem_sel, wb_sel, rdata, waits, exp_we, chk, exp_data
        vecs[0]  = mk(32'h1234_5678, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678);
        vecs[1]  = mk(32'h0000_0002, 0, 0, 3, 1, 1, 3'b000, 1, 32'h0080_0000, 3, 1, 1, 32'hFFFF_FF80);
        vecs[2]  = mk(32'h0000_0002, 0, 0, 3, 1, 1, 3'b100, 1, 32'h0080_0000, 3, 1, 1, 32'h0000_0080);
        vecs[3]  = mk(32'h0000_1002, 0, 0, 7, 1, 1, 3'b101, 1, 32'hBEEF_0000, 1, 1, 1, 32'h0000_BEEF);
        vecs[4]  = mk(32'h0000_1002, 0, 0, 7, 1, 1, 3'b001, 1, 32'hBEEF_0000, 1, 1, 1, 32'hFFFF_BEEF);
        vecs[5]  = mk(32'h0000_0000, 0, 0, 8, 1, 1, 3'b010, 1, 32'hCAFE_F00D, 0, 1, 1, 32'hCAFE_F00D);
        vecs[6]  = mk(32'h0000_0001, 0, 0, 9, 1, 1, 3'b000, 1, 32'h0000_7F00, 2, 1, 1, 32'h0000_007F);
        vecs[7]  = mk(32'h0000_0099, 32'h0000_0104, 0, 1, 1, 0, 0, 2'b10, 0, 0, 1, 1, 32'h0000_0104);
        vecs[8]  = mk(32'h0000_0099, 0, 32'hABCD_E000, 2, 1, 0, 0, 2'b11, 0, 0, 1, 1, 32'hABCD_E000);
        vecs[9]  = mk(32'h55AA_55AA, 0, 0, 4, 1, 0, 0, 2'b01, 32'hFFFF_FFFF, 0, 1, 1, 32'h55AA_55AA);
        vecs[10] = mk(32'h0000_DEAD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(32'h0000_0040, 0, 0, 6, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(32'h0000_0077, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(32'h0000_0077, 0, 0, 11, 1, 2'b11, 0, 0, 0, 0, 1, 1, 32'h0000_0077);
        vecs[14] = mk(32'h0000_0003, 0, 0, 13, 1, 1, 3'b001, 1, 32'h8001_1234, 1, 1, 1, 32'hFFFF_8001);
        vecs[15] = mk(32'h0000_0001, 0, 0, 14, 1, 1, 3'b111, 1, 32'h0F0F_0F0F, 0, 1, 1, 32'h0F0F_0F0F);
        vecs[16] = mk(32'h0000_0007, 0, 0, 15, 1, 1, 3'b100, 1, 32'hF100_0000, 2, 1, 1, 32'h0000_00F1);
        vecs[17] = mk(32'h0000_0000, 0, 0, 16, 1, 1, 3'b101, 1, 32'h1234_F00D, 1, 1, 1, 32'h0000_F00D);

        idleInputs();
        doReset();
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_we", {31'd0, wb_reg_we}, 32'd0);
        checkOutput("reset_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("reset_data", wb_data, 32'd0);
        checkCount("reset");

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Load data arriving while nothing is pending must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("stray_rvalid_we", {31'd0, wb_reg_we}, 32'd0);
        checkOutput("stray_rvalid_ready", {31'd0, in_ready}, 32'd1);
        checkCount("stray_rvalid");

        // Four back-to-back ALU ops, then a load accepted straight out of COMMIT.
        in_valid  = 1'b1;
        in_reg_we = 1'b1;
        in_mem_op = 2'b00;
        in_wb_sel = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            in_rd         = 5'(k);
            in_alu_result = 32'h0000_0100 + 32'(k);
            tick();
            exp_count++;
            checkOutput($sformatf("b2b%0d_we", k), {31'd0, wb_reg_we}, 32'd1);
            checkOutput($sformatf("b2b%0d_rd", k), {27'd0, wb_rd}, 32'(k));
            checkOutput($sformatf("b2b%0d_data", k), wb_data, 32'h0000_0100 + 32'(k));
        end
        checkCount("b2b");
        in_rd         = 5'd20;
        in_alu_result = 32'd0;
        in_mem_op     = 2'b01;
        in_mem_sel    = 3'b010;
        in_wb_sel     = 2'b01;
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_load_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("b2b_load_we", {31'd0, wb_reg_we}, 32'd0);
        checkOutput("b2b_load_hold_rd", {27'd0, wb_rd}, 32'd4);
        checkOutput("b2b_load_hold_data", wb_data, 32'h0000_0104);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        tick();
        mem_rvalid = 1'b0;
        exp_count++;
        checkOutput("b2b_load_commit_we", {31'd0, wb_reg_we}, 32'd1);
        checkOutput("b2b_load_commit_rd", {27'd0, wb_rd}, 32'd20);
        checkOutput("b2b_load_commit_data", wb_data, 32'h1357_9BDF);
        checkCount("b2b_load");
        tick();

        // Reset while a load is pending discards it.
        in_valid  = 1'b1;
        in_rd     = 5'd12;
        in_mem_op = 2'b01;
        tick();
        in_valid = 1'b0;
        checkOutput("rstwait_ready", {31'd0, in_ready}, 32'd0);
        doReset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("rstwait_we", {31'd0, wb_reg_we}, 32'd0);
        checkOutput("rstwait_ready_after", {31'd0, in_ready}, 32'd1);
        checkOutput("rstwait_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("rstwait_data", wb_data, 32'd0);
        checkCount("rstwait");
        tick();
        checkOutput("rstwait_we_later", {31'd0, wb_reg_we}, 32'd0);

        // Sixteen commits wrap the 4-bit counter back to zero.
        idleInputs();
        in_valid  = 1'b1;
        in_rd     = 5'd1;
        in_reg_we = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_count++;
            if (k == 15) begin
                checkOutput("wrap_at15", {28'd0, retire_count4}, 32'd15);
            end
        end
        in_valid = 1'b0;
        checkOutput("wrap_count4_zero", {28'd0, retire_count4}, 32'd0);
        checkOutput("wrap_count32", retire_count, 32'd16);
        tick();
        checkOutput("wrap_idle_we", {31'd0, wb_reg_we}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
